trace_match_scorer: RTL and testbench

Downstream consumer of the random 16-bit spell trace (4x4 grid, bit index = row*4 + col) and its save_trace flag. Latches the target trace, shows it for a fixed time, then records the player's drawn cells. It compares the drawn cells against the target, reports the mismatch count and match status, and keeps a running score. It closes the loop with a trace_ack handshake so the generator can start a new trace.

---
 rtl/trace_match_scorer.sv | 108 ++++++++++
 tb/tb_trace_match_scorer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/trace_match_scorer.sv
// Spell-trace scorer: latches a 4x4 target, shows it, records the player's drawn cells,
// then scores the drawing and acknowledges the generator with a 4-phase handshake.
module trace_match_scorer #(
    parameter int SHOW_CYCLES = 5,
    parameter int DRAW_CYCLES = 50,
    parameter int SCORE_W     = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [15:0]        trace,
    input  logic               save_trace,
    input  logic               cell_valid,
    input  logic [3:0]         cell_idx,
    input  logic               done_btn,
    output logic [15:0]        target_show,
    output logic [15:0]        player_mask,
    output logic               result_valid,
    output logic               match,
    output logic [4:0]         mismatch_count,
    output logic [SCORE_W-1:0] score,
    output logic               trace_ack,
    output logic               busy
);

    localparam int TMAX    = (SHOW_CYCLES > DRAW_CYCLES) ? SHOW_CYCLES : DRAW_CYCLES;
    localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TIMER_W-1:0] SHOW_LOAD = TIMER_W'(SHOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DRAW_LOAD = TIMER_W'(DRAW_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SHOW, S_DRAW, S_COMPARE, S_RESULT
    } state_t;

    state_t             state, state_next;
    logic [TIMER_W-1:0] timer;
    logic [15:0]        target;

    function automatic logic [4:0] popcount16(input logic [15:0] x);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) cnt = cnt + 5'(x[i]);
        return cnt;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (save_trace) state_next = S_SHOW;
            S_SHOW:    if (timer == '0) state_next = S_DRAW;
            S_DRAW:    if (done_btn || timer == '0) state_next = S_COMPARE;
            S_COMPARE: state_next = S_RESULT;
            S_RESULT:  if (!save_trace) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; flag outputs follow the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            target         <= '0;
            timer          <= '0;
            player_mask    <= '0;
            mismatch_count <= '0;
            match          <= 1'b0;
            score          <= '0;
            target_show    <= '0;
            result_valid   <= 1'b0;
            trace_ack      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (save_trace) begin
                    target         <= trace;
                    timer          <= SHOW_LOAD;
                    player_mask    <= '0;
                    match          <= 1'b0;
                    mismatch_count <= '0;
                end
                S_SHOW: timer <= (timer == '0) ? DRAW_LOAD : timer - 1'b1;
                S_DRAW: begin
                    // A touch coinciding with the exit condition still counts.
                    if (cell_valid) player_mask[cell_idx] <= 1'b1;
                    if (!(done_btn || timer == '0)) timer <= timer - 1'b1;
                end
                S_COMPARE: begin
                    mismatch_count <= popcount16(target ^ player_mask);
                    match          <= (target == player_mask);
                    if (target == player_mask) score <= sat_inc(score);
                end
                default: ;
            endcase
            target_show  <= (state_next == S_SHOW) ? ((state == S_IDLE) ? trace : target) : '0;
            result_valid <= (state_next == S_RESULT);
            trace_ack    <= (state_next == S_RESULT);
            busy         <= (state_next != S_IDLE);
        end
    end

endmodule

// File: tb/tb_trace_match_scorer.sv
// Directed bench for trace_match_scorer with SHOW_CYCLES=4, DRAW_CYCLES=8, SCORE_W=3.
module tb_trace_match_scorer;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] trace;
    logic        save_trace;
    logic        cell_valid;
    logic [3:0]  cell_idx;
    logic        done_btn;
    logic [15:0] target_show;
    logic [15:0] player_mask;
    logic        result_valid;
    logic        match;
    logic [4:0]  mismatch_count;
    logic [2:0]  score;
    logic        trace_ack;
    logic        busy;

    int vectors    = 0;
    int miscompares = 0;

    trace_match_scorer #(.SHOW_CYCLES(4), .DRAW_CYCLES(8), .SCORE_W(3)) dut (
        .clk(clk), .resetn(resetn), .trace(trace), .save_trace(save_trace),
        .cell_valid(cell_valid), .cell_idx(cell_idx), .done_btn(done_btn),
        .target_show(target_show), .player_mask(player_mask), .result_valid(result_valid),
        .match(match), .mismatch_count(mismatch_count), .score(score),
        .trace_ack(trace_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; save_trace = 1'b0; trace = 16'h0; cell_valid = 1'b0;
        cell_idx = 4'd0; done_btn = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        tick();
        vectors++; if (target_show !== 16'h0) begin miscompares++; $display("FAIL reset_target_show: got %h want 0000", target_show); end
        vectors++; if (player_mask !== 16'h0) begin miscompares++; $display("FAIL reset_player_mask: got %h want 0000", player_mask); end
        vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL reset_result_valid: got %b want 0", result_valid); end
        vectors++; if (match !== 1'b0) begin miscompares++; $display("FAIL reset_match: got %b want 0", match); end
        vectors++; if (mismatch_count !== 5'd0) begin miscompares++; $display("FAIL reset_mismatch: got %0d want 0", mismatch_count); end
        vectors++; if (score !== 3'd0) begin miscompares++; $display("FAIL reset_score: got %0d want 0", score); end
        vectors++; if (trace_ack !== 1'b0) begin miscompares++; $display("FAIL reset_trace_ack: got %b want 0", trace_ack); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        tick(); tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_stays: busy got %b want 0", busy); end
    endtask

    task automatic test_exact_match();
        trace = 16'h8421; save_trace = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++; if (target_show !== 16'h8421) begin miscompares++; $display("FAIL exact_show[%0d]: got %h want 8421", i, target_show); end
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL exact_busy[%0d]: got %b want 1", i, busy); end
        end
        tick();
        vectors++; if (target_show !== 16'h0) begin miscompares++; $display("FAIL exact_show_end: got %h want 0000", target_show); end
        cell_valid = 1'b1;
        cell_idx = 4'd0;  tick();
        cell_idx = 4'd5;  tick();
        cell_idx = 4'd10; tick();
        cell_idx = 4'd15; tick();
        cell_valid = 1'b0; done_btn = 1'b1;
        tick();
        done_btn = 1'b0;
        vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL exact_compare_cycle: result_valid got %b want 0", result_valid); end
        tick();
        vectors++; if (result_valid !== 1'b1) begin miscompares++; $display("FAIL exact_result_valid: got %b want 1", result_valid); end
        vectors++; if (player_mask !== 16'h8421) begin miscompares++; $display("FAIL exact_mask: got %h want 8421", player_mask); end
        vectors++; if (match !== 1'b1) begin miscompares++; $display("FAIL exact_match: got %b want 1", match); end
        vectors++; if (mismatch_count !== 5'd0) begin miscompares++; $display("FAIL exact_mismatch: got %0d want 0", mismatch_count); end
        vectors++; if (score !== 3'd1) begin miscompares++; $display("FAIL exact_score: got %0d want 1", score); end
        vectors++; if (trace_ack !== 1'b1) begin miscompares++; $display("FAIL exact_ack: got %b want 1", trace_ack); end
        tick(); tick();
        vectors++; if (trace_ack !== 1'b1) begin miscompares++; $display("FAIL exact_ack_held: got %b want 1", trace_ack); end
        save_trace = 1'b0;
        tick();
        vectors++; if (trace_ack !== 1'b0) begin miscompares++; $display("FAIL exact_ack_drop: got %b want 0", trace_ack); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL exact_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_timeout();
        trace = 16'h000F; save_trace = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        cell_valid = 1'b1;
        cell_idx = 4'd0; tick();
        cell_idx = 4'd1; tick();
        cell_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        tick();
        vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL timeout_early: result_valid got %b want 0", result_valid); end
        tick();
        vectors++; if (result_valid !== 1'b1) begin miscompares++; $display("FAIL timeout_result_valid: got %b want 1", result_valid); end
        vectors++; if (player_mask !== 16'h0003) begin miscompares++; $display("FAIL timeout_mask: got %h want 0003", player_mask); end
        vectors++; if (mismatch_count !== 5'd2) begin miscompares++; $display("FAIL timeout_mismatch: got %0d want 2", mismatch_count); end
        vectors++; if (match !== 1'b0) begin miscompares++; $display("FAIL timeout_match: got %b want 0", match); end
        vectors++; if (score !== 3'd1) begin miscompares++; $display("FAIL timeout_score: got %0d want 1", score); end
        save_trace = 1'b0;
        tick();
    endtask

    task automatic test_overdraw();
        trace = 16'h0001; save_trace = 1'b1;
        tick();
        trace = 16'hFFFF;
        for (int i = 0; i < 4; i++) tick();
        cell_valid = 1'b1;
        cell_idx = 4'd0; tick();
        cell_idx = 4'd0; tick();
        cell_idx = 4'd3; done_btn = 1'b1; tick();
        cell_valid = 1'b0; done_btn = 1'b0;
        tick();
        vectors++; if (result_valid !== 1'b1) begin miscompares++; $display("FAIL overdraw_result_valid: got %b want 1", result_valid); end
        vectors++; if (player_mask !== 16'h0009) begin miscompares++; $display("FAIL overdraw_mask: got %h want 0009", player_mask); end
        vectors++; if (mismatch_count !== 5'd1) begin miscompares++; $display("FAIL overdraw_mismatch: got %0d want 1", mismatch_count); end
        vectors++; if (match !== 1'b0) begin miscompares++; $display("FAIL overdraw_match: got %b want 0", match); end
        save_trace = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int exp_score;
        exp_score = 1;
        trace = 16'h0000;
        for (int r = 0; r < 8; r++) begin
            save_trace = 1'b1;
            tick();
            for (int i = 0; i < 4; i++) tick();
            done_btn = 1'b1; tick();
            done_btn = 1'b0; tick();
            exp_score = (exp_score < 7) ? exp_score + 1 : 7;
            vectors++; if (match !== 1'b1) begin miscompares++; $display("FAIL b2b_match[%0d]: got %b want 1", r, match); end
            vectors++; if (score !== 3'(exp_score)) begin miscompares++; $display("FAIL b2b_score[%0d]: got %0d want %0d", r, score, exp_score); end
            if (r != 7) begin
                save_trace = 1'b0;
                tick();
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (result_valid !== 1'b1 || trace_ack !== 1'b1) begin miscompares++; $display("FAIL b2b_hold[%0d]: rv/ack got %b%b want 11", i, result_valid, trace_ack); end
            vectors++; if (target_show !== 16'h0) begin miscompares++; $display("FAIL b2b_no_recapture[%0d]: target_show got %h want 0000", i, target_show); end
        end
        save_trace = 1'b0;
        tick();
        vectors++; if (busy !== 1'b0 || result_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_release: busy/rv got %b%b want 00", busy, result_valid); end
        vectors++; if (score !== 3'd7) begin miscompares++; $display("FAIL b2b_saturate: got %0d want 7", score); end
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_hold: busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_draw();
        resetn = 1'b0; tick();
        resetn = 1'b1;
        trace = 16'h0000;
        for (int r = 0; r < 2; r++) begin
            save_trace = 1'b1; tick();
            for (int i = 0; i < 4; i++) tick();
            done_btn = 1'b1; tick();
            done_btn = 1'b0; tick();
            save_trace = 1'b0; tick();
        end
        trace = 16'h0030; save_trace = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        cell_valid = 1'b1;
        cell_idx = 4'd4; tick();
        cell_idx = 4'd5; tick();
        cell_valid = 1'b0;
        vectors++; if (player_mask !== 16'h0030) begin miscompares++; $display("FAIL middraw_mask: got %h want 0030", player_mask); end
        vectors++; if (score !== 3'd2) begin miscompares++; $display("FAIL middraw_score: got %0d want 2", score); end
        resetn = 1'b0; save_trace = 1'b0;
        tick();
        resetn = 1'b1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL middraw_busy: got %b want 0", busy); end
        vectors++; if (score !== 3'd0) begin miscompares++; $display("FAIL middraw_score_clr: got %0d want 0", score); end
        vectors++; if (player_mask !== 16'h0) begin miscompares++; $display("FAIL middraw_mask_clr: got %h want 0000", player_mask); end
        vectors++; if (trace_ack !== 1'b0) begin miscompares++; $display("FAIL middraw_ack: got %b want 0", trace_ack); end
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL middraw_idle: busy got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_exact_match();
        test_timeout();
        test_overdraw();
        test_back_to_back();
        test_reset_mid_draw();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
